// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding and width helpers for the PLL lock sequencer.
package pll_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // One counter serves every timed state, so size it for the longest window.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int unsigned retry_width(input int unsigned max_retries);
    return (max_retries == 0) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic 2-flop synchronizer for asynchronous level inputs.
// Latency: 2 cycles from input change to output change.
module sync_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_dat;
      r_sync <= r_meta;
    end
  end

  assign o_dat = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, qualifies lock and gates the system reset until lock is stable.
// Outputs are registered from the next state, so they move on the same edge as the state.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                pll_locked,
  input  logic                                restart,
  output logic                                pll_resetn,
  output logic                                sys_resetn,
  output logic                                ready,
  output logic                                fault,
  output logic [retry_width(MAX_RETRIES)-1:0] retries,
  output logic [7:0]                          lost_count
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RW = retry_width(MAX_RETRIES);

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  logic          w_locked_s;
  state_e        w_nxt;
  logic          w_xfer;
  logic          w_retry_inc;
  logic          w_retry_clr;
  logic          w_lost_inc;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retries;
  logic [7:0]    r_lost_count;
  logic          r_pll_resetn;
  logic          r_sys_resetn;
  logic          r_ready;
  logic          r_fault;

  sync_ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .i_dat (pll_locked),
    .o_dat (w_locked_s)
  );

  // restart overrides every other condition, including a same-cycle RUN entry.
  always_comb begin
    w_nxt       = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_lost_inc  = 1'b0;
    if (restart) begin
      w_nxt       = ST_RESET;
      w_retry_clr = 1'b1;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_cnt == RESET_LAST) w_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_nxt = ST_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            if (r_retries == RETRY_MAX) begin
              w_nxt = ST_FAULT;
            end else begin
              w_nxt       = ST_RESET;
              w_retry_inc = 1'b1;
            end
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            w_nxt = ST_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_nxt       = ST_RUN;
            w_retry_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            w_nxt      = ST_LOST;
            w_lost_inc = 1'b1;
          end
        end
        ST_LOST:  w_nxt = ST_RESET;
        ST_FAULT: w_nxt = ST_FAULT;
        default:  w_nxt = ST_RESET;
      endcase
    end
  end

  assign w_xfer = restart || (w_nxt != r_state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      r_retries    <= '0;
      r_lost_count <= '0;
      r_pll_resetn <= 1'b0;
      r_sys_resetn <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_xfer ? '0 : r_cnt + 1'b1;
      if (w_retry_clr)      r_retries <= '0;
      else if (w_retry_inc) r_retries <= r_retries + 1'b1;
      if (w_lost_inc && (r_lost_count != 8'hFF)) r_lost_count <= r_lost_count + 8'd1;
      r_pll_resetn <= !((w_nxt == ST_RESET) || (w_nxt == ST_FAULT));
      r_sys_resetn <= (w_nxt == ST_RUN);
      r_ready      <= (w_nxt == ST_RUN);
      r_fault      <= (w_nxt == ST_FAULT);
    end
  end

  assign pll_resetn = r_pll_resetn;
  assign sys_resetn = r_sys_resetn;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign retries    = r_retries;
  assign lost_count = r_lost_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-plus-random bench for pll_lock_sequencer; expected timings come from
// the sequencing rules expressed as latency arithmetic and simple counters.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int SYNC_LAT    = 2;
  localparam int LOCK_TO_RUN = SYNC_LAT + 1 + SC;
  localparam int LOSS_LAT    = SYNC_LAT + 1;
  localparam int WARM_TO_RUN = RC + 1 + SC;

  localparam int P_PLLR  = 0;
  localparam int P_SYSR  = 1;
  localparam int P_READY = 2;
  localparam int P_FAULT = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetn;
  logic       sys_resetn;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
  logic [7:0] lost_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_lost = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_resetn (pll_resetn),
    .sys_resetn (sys_resetn),
    .ready      (ready),
    .fault      (fault),
    .retries    (retries),
    .lost_count (lost_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      P_PLLR:  return pll_resetn;
      P_SYSR:  return sys_resetn;
      P_READY: return ready;
      default: return fault;
    endcase
  endfunction

  // Edges until sig(sel) equals val (0 if already there); budget-bounded.
  task automatic wait_level(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Edges for which sig(sel) keeps val, counting the edge where it changes.
  task automatic count_while(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (sig(sel) !== val) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_resetn"}, pll_resetn, 0);
    check({tag, "_sys_resetn"}, sys_resetn, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_retries"}, retries, 0);
    check({tag, "_lost_count"}, lost_count, 0);
  endtask

  initial begin
    int n;
    int d;
    int g;

    // Power-on reset values
    resetn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    resetn = 1'b1;

    // Clean lock at a random point inside the lock window
    wait_level(P_PLLR, 1'b1, 20, n);
    check("por_to_pll_release", n, RC);
    d = $urandom_range(0, 25);
    repeat (d) tick();
    pll_locked = 1'b1;
    wait_level(P_SYSR, 1'b1, 100, n);
    check("clean_lock_latency", n, LOCK_TO_RUN);
    check("clean_ready", ready, 1);
    check("clean_retries", retries, 0);
    check("clean_pll_resetn", pll_resetn, 1);
    check("clean_fault", fault, 0);

    // Repeated loss of lock in RUN; lost_count must saturate
    for (int k = 1; k <= 300; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      pll_locked = 1'b0;
      wait_level(P_SYSR, 1'b0, 10, n);
      check("loss_latency", n, LOSS_LAT);
      exp_lost = (exp_lost == 255) ? 255 : exp_lost + 1;
      check("lost_count", lost_count, exp_lost);
      check("lost_ready", ready, 0);
      check("lost_pll_still_on", pll_resetn, 1);
      wait_level(P_PLLR, 1'b0, 5, n);
      check("lost_to_pll_reset", n, 1);
      count_while(P_PLLR, 1'b0, 20, n);
      check("loss_pll_reset_hold", n, RC);
      d = $urandom_range(0, 20);
      repeat (d) tick();
      pll_locked = 1'b1;
      wait_level(P_READY, 1'b1, 100, n);
      check("relock_latency", n, LOCK_TO_RUN);
      check("relock_retries", retries, 0);
    end

    // restart wins over a same-cycle loss in RUN and leaves lost_count alone
    pll_locked = 1'b0;
    restart    = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_pll_resetn", pll_resetn, 0);
    check("restart_sys_resetn", sys_resetn, 0);
    check("restart_lost_kept", lost_count, exp_lost);
    check("restart_retries", retries, 0);
    count_while(P_PLLR, 1'b0, 20, n);
    check("restart_pll_reset_hold", n, RC);

    // Never locks: MR+1 full attempts then FAULT
    for (int a = 0; a <= MR; a++) begin
      check("attempt_retries", retries, a);
      count_while(P_PLLR, 1'b1, 100, n);
      check("attempt_wait_len", n, LT);
      if (a < MR) begin
        count_while(P_PLLR, 1'b0, 20, n);
        check("attempt_reset_len", n, RC);
      end
    end
    check("fault_flag", fault, 1);
    check("fault_pll_resetn", pll_resetn, 0);
    check("fault_sys_resetn", sys_resetn, 0);
    check("fault_ready", ready, 0);
    check("fault_retries", retries, MR);
    pll_locked = 1'b1;
    repeat ($urandom_range(5, 50)) tick();
    check("fault_sticky", fault, 1);
    check("fault_sticky_pll", pll_resetn, 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("fault_exit_flag", fault, 0);
    check("fault_exit_retries", retries, 0);
    check("fault_exit_pll_resetn", pll_resetn, 0);
    wait_level(P_READY, 1'b1, 100, n);
    check("restart_to_run_prelocked", n, WARM_TO_RUN);

    // restart on the cycle the stable window completes
    restart = 1'b1;
    tick();
    restart = 1'b0;
    wait_level(P_PLLR, 1'b1, 20, n);
    check("simul_pll_release", n, RC);
    repeat (SC) tick();
    check("simul_pre_ready", ready, 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("simul_ready", ready, 0);
    check("simul_sys_resetn", sys_resetn, 0);
    check("simul_pll_resetn", pll_resetn, 0);
    wait_level(P_READY, 1'b1, 100, n);
    check("simul_recover", n, WARM_TO_RUN);

    // Glitch during STABLE while one retry is already spent
    pll_locked = 1'b0;
    restart    = 1'b1;
    tick();
    restart = 1'b0;
    count_while(P_PLLR, 1'b0, 20, n);
    check("glitch_first_reset", n, RC);
    count_while(P_PLLR, 1'b1, 100, n);
    check("glitch_first_timeout", n, LT);
    count_while(P_PLLR, 1'b0, 20, n);
    check("glitch_second_reset", n, RC);
    check("glitch_retries_before", retries, 1);
    pll_locked = 1'b1;
    repeat (SYNC_LAT + 1) tick();
    g = $urandom_range(1, 5);
    repeat (g) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    check("glitch_no_release", sys_resetn, 0);
    check("glitch_retries_kept", retries, 1);
    wait_level(P_SYSR, 1'b1, 100, n);
    check("glitch_relock_latency", n, LOCK_TO_RUN);
    check("glitch_retries_cleared", retries, 0);

    // Asynchronous reset while in RUN
    check("arst_pre_ready", ready, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("arst");
    tick();
    resetn = 1'b1;
    wait_level(P_READY, 1'b1, 100, n);
    check("arst_recover", n, WARM_TO_RUN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
